dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
// - Owns byte-enable generation, store lane steering and load sign/zero extension for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
// - Stalls the pipeline while a CPU load waits for data or while DBG holds the memory.
// - Sits between memory_cycle-style MEM-stage logic and a synchronous SRAM macro with 1-cycle read latency.
// PARAMETERS
// - ADDR_W      12  byte-address width presented to memory; word index = addr[ADDR_W-1:2]
// - STARVE_MAX   8  consecutive cycles DBG may lose to CPU before it is forced a grant (>=1)
// PORTS
// - clk          in   1        system clock, rising edge
// - rst_n        in   1        asynchronous reset, active low
// - cpu_req      in   1        MEM-stage access valid (MemRead_M | MemWrite_M)
// - cpu_we       in   1        1=store, 0=load
// - cpu_funct3   in   3        access size/sign, RV32I encoding
// - cpu_addr     in   32       byte address (ALU_Result_M)
// - cpu_wdata    in   32       store data, right-aligned
// - cpu_stall    out  1        hold pipeline (combinational)
// - cpu_rdata    out  32       extended load data, valid with cpu_rvalid
// - cpu_rvalid   out  1        one-cycle pulse, load data valid
// - cpu_misalign out  1        one-cycle pulse, access rejected as misaligned
// - dbg_req      in   1        debug request; held with fields stable until dbg_ready
// - dbg_we       in   1        1=word write, 0=word read
// - dbg_addr     in   32       byte address, bits[1:0] ignored
// - dbg_wdata    in   32       write word
// - dbg_ready    out  1        request accepted this cycle (req & ready = handshake)
// - dbg_rdata    out  32       read word, valid with dbg_rvalid
// - dbg_rvalid   out  1        one-cycle pulse
// - mem_en       out  1        memory access strobe
// - mem_be       out  4        byte write enables (0 for reads)
// - mem_addr     out  ADDR_W-2 word index
// - mem_wdata    out  32       lane-steered write word
// - mem_rdata    in   32       read word, valid the cycle after a read strobe
// BEHAVIOUR
// - Reset: state IDLE, starve_cnt=0, all registered outputs 0; pending read discarded (no rvalid after reset).
// - FSM states: IDLE, WAIT_CPU, WAIT_DBG.
// - IDLE arbitration: CPU wins unless starve_cnt==STARVE_MAX; DBG wins if CPU idle or forced.
// - starve_cnt: +1 each IDLE cycle dbg_req is present and loses; cleared on DBG grant; saturates.
// - CPU store granted: mem_en=1, mem_be per size/addr[1:0]; done same cycle; cpu_stall=0; stays IDLE.
// - CPU load granted: mem_en=1, mem_be=0, cpu_stall=1, -> WAIT_CPU.
// - WAIT_CPU: cpu_rdata=extended mem_rdata lanes, cpu_rvalid=1, cpu_stall=0, -> IDLE; no new grant this cycle.
// - DBG granted: dbg_ready=1, mem_en=1; write: mem_be=4'hF, stay IDLE; read: -> WAIT_DBG.
// - WAIT_DBG: dbg_rdata=mem_rdata, dbg_rvalid=1, -> IDLE.
// - cpu_stall=1 whenever cpu_req is high and CPU is not granted a store or not in WAIT_CPU completion.
// - Misalign: SH/LH/LHU with addr[0]=1, SW/LW with addr[1:0]!=0, or undefined funct3: no mem access,
//   cpu_misalign pulses, cpu_stall=0 (pipeline proceeds; trap handling elsewhere).
// - Byte lanes: SB be=1<<a[1:0], wdata=byte replicated x4; SH be=3<<a[1:0], half replicated x2; SW be=F.
// - Loads: byte select a[1:0], half select a[1]; LB/LH sign-extend, LBU/LHU zero-extend.
// - Address bits above ADDR_W ignored (wrap, no error).
// - Simultaneous cpu_req & dbg_req in WAIT_*: both wait; arbitration resumes in next IDLE cycle.
// STRUCTURE
// - Package dmem_pkg: funct3 constants (F3_B/H/W/BU/HU), state enum, be/lane helper functions.
// - Sub-module lsu_align: combinational be/wdata steering and load extension; FSM + counter in top.
// TESTING
// - SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_be=F, cpu_stall 1 cycle, cpu_rvalid next cycle, rdata=0xDEADBEEF.
// - SB 0x80 @0x13, LB @0x13 -> mem_be=4'b1000; rdata=0xFFFFFF80; LBU -> 0x00000080.
// - LH @0x11 -> cpu_misalign=1, mem_en=0, cpu_stall=0, no rvalid.
// - cpu_req loads every cycle + dbg_req held -> dbg_ready asserted within STARVE_MAX IDLE cycles; counter cleared.
// - dbg read @0x10 while CPU idle -> dbg_ready same cycle, dbg_rvalid next cycle with stored word.
// - rst_n low in WAIT_CPU -> all outputs 0 asynchronously, no cpu_rvalid after release, state IDLE.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RV32I load/store size codes,
// arbiter states and the byte-lane helpers used by lsu_align.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CPU = 2'd1,
    WAIT_DBG = 2'd2
  } state_e;

  // Unsigned sizes exist only for loads; any other code is rejected like a misalignment.
  function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3)
      F3_B:    r = 1'b0;
      F3_H:    r = off[0];
      F3_W:    r = (off != 2'b00);
      F3_BU:   r = we;
      F3_HU:   r = we | off[0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] r;
    case (f3)
      F3_B:    r = 4'b0001 << off;
      F3_H:    r = 4'b0011 << off;
      F3_W:    r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {4{data[7:0]}};
      F3_H:    r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'b0, b};
      F3_HU:   r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and SRAM signals around the arbiter. slave = arbiter side,
// master = environment (MEM stage, debug loader and SRAM macro).
interface dmem_arbiter_if #(parameter int ADDR_W = 12);
  import dmem_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [2:0]        cpu_funct3;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_misalign;

  // dbg_req is a valid that must stay high with stable fields until dbg_ready;
  // the cycle where both are high is the single transfer, no backpressure on rvalid.
  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_ready;
  logic [31:0]       dbg_rdata;
  logic              dbg_rvalid;

  logic              mem_en;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  state_e            arb_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid, cpu_misalign,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rdata, dbg_rvalid,
    output mem_en, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output arb_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid, cpu_misalign,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  arb_state
  );

endinterface

// File: rtl/dmem_arbiter_lsu_align.sv
// Combinational store lane steering / byte enables and load extraction with extension.
module lsu_align
  import dmem_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data,
  output logic        bad
);

  assign bad      = access_bad(st_we, st_f3, st_off);
  assign st_be    = st_we ? store_be(st_f3, st_off) : 4'b0000;
  assign st_lanes = store_lanes(st_f3, st_wdata);
  assign ld_data  = load_extend(ld_f3, ld_off, mem_rdata);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data SRAM between the MEM stage and the debug port,
// with a starvation counter that eventually forces a debug grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 8
) (
  input logic         clk,
  input logic         rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic [1:0]    ld_off_q, ld_off_d;

  logic [3:0]    st_be;
  logic [31:0]   st_lanes;
  logic [31:0]   ld_data;
  logic          bad;
  logic          cpu_ok;
  logic          dbg_win;

  lsu_align u_align (
    .st_we     (bus.cpu_we),
    .st_f3     (bus.cpu_funct3),
    .st_off    (bus.cpu_addr[1:0]),
    .st_wdata  (bus.cpu_wdata),
    .ld_f3     (ld_f3_q),
    .ld_off    (ld_off_q),
    .mem_rdata (bus.mem_rdata),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .ld_data   (ld_data),
    .bad       (bad)
  );

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W], bus.dbg_addr[31:ADDR_W], bus.dbg_addr[1:0]};

  assign cpu_ok        = bus.cpu_req & ~bad;
  assign dbg_win       = bus.dbg_req & (~cpu_ok | (starve_q == SMAX));
  assign bus.arb_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
    end
  end

  // Outputs are held at zero while rst_n is low, even with requests still asserted.
  always_comb begin
    state_d          = state_q;
    starve_d         = starve_q;
    ld_f3_d          = ld_f3_q;
    ld_off_d         = ld_off_q;
    bus.cpu_stall    = 1'b0;
    bus.cpu_rdata    = '0;
    bus.cpu_rvalid   = 1'b0;
    bus.cpu_misalign = 1'b0;
    bus.dbg_ready    = 1'b0;
    bus.dbg_rdata    = '0;
    bus.dbg_rvalid   = 1'b0;
    bus.mem_en       = 1'b0;
    bus.mem_be       = 4'b0000;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          bus.cpu_misalign = bus.cpu_req & bad;
          if (dbg_win) begin
            bus.dbg_ready = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.dbg_addr[ADDR_W-1:2];
            bus.cpu_stall = cpu_ok;
            starve_d      = '0;
            if (bus.dbg_we) begin
              bus.mem_be    = 4'hF;
              bus.mem_wdata = bus.dbg_wdata;
            end else begin
              state_d = WAIT_DBG;
            end
          end else if (cpu_ok) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.cpu_addr[ADDR_W-1:2];
            if (bus.dbg_req && starve_q != SMAX) starve_d = starve_q + CW'(1);
            if (bus.cpu_we) begin
              bus.mem_be    = st_be;
              bus.mem_wdata = st_lanes;
            end else begin
              bus.cpu_stall = 1'b1;
              ld_f3_d       = bus.cpu_funct3;
              ld_off_d      = bus.cpu_addr[1:0];
              state_d       = WAIT_CPU;
            end
          end
        end
        WAIT_CPU: begin
          bus.cpu_rdata  = ld_data;
          bus.cpu_rvalid = 1'b1;
          state_d        = IDLE;
        end
        WAIT_DBG: begin
          bus.dbg_rdata  = bus.mem_rdata;
          bus.dbg_rvalid = 1'b1;
          bus.cpu_stall  = bus.cpu_req;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: SRAM model, scoreboard queues for load data,
// immediate-assertion checks and a one-line summary.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] cpu_exp_q[$];
  logic [31:0] dbg_exp_q[$];
  logic [31:0] sram [0:1023];

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous SRAM, 1-cycle read latency
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
    bus.mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_be == 4'b0000) bus.mem_rdata <= sram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) sram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop expected read data whenever the DUT signals rvalid
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.cpu_rvalid) begin
      if (cpu_exp_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(bus.cpu_rvalid), 32'd0);
      else begin
        e = cpu_exp_q.pop_front();
        chk("cpu_rdata", bus.cpu_rdata, e);
      end
    end
    if (bus.dbg_rvalid) begin
      if (dbg_exp_q.size() == 0) chk("dbg_rvalid_unexpected", 32'(bus.dbg_rvalid), 32'd0);
      else begin
        e = dbg_exp_q.pop_front();
        chk("dbg_rdata", bus.dbg_rdata, e);
      end
    end
  end

  // driver tasks
  task automatic cpu_drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_funct3 = f3;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
  endtask

  task automatic cpu_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    @(posedge clk); #1;
    cpu_drive(1'b1, f3, addr, wdata);
    @(negedge clk);
    chk("st_en", 32'(bus.mem_en), 32'd1);
    chk("st_be", 32'(bus.mem_be), 32'(exp_be));
    chk("st_wdata", bus.mem_wdata, exp_wdata);
    chk("st_addr", 32'(bus.mem_addr), 32'(addr[ADDR_W-1:2]));
    chk("st_stall", 32'(bus.cpu_stall), 32'd0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic cpu_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    @(posedge clk); #1;
    cpu_drive(1'b0, f3, addr, 32'h0);
    @(negedge clk);
    chk("ld_en", 32'(bus.mem_en), 32'd1);
    chk("ld_be", 32'(bus.mem_be), 32'd0);
    chk("ld_stall", 32'(bus.cpu_stall), 32'd1);
    chk("ld_addr", 32'(bus.mem_addr), 32'(addr[ADDR_W-1:2]));
    cpu_exp_q.push_back(exp);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ld_done_stall", 32'(bus.cpu_stall), 32'd0);
    chk("ld_done_no_grant", 32'(bus.mem_en), 32'd0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic cpu_reject(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk); #1;
    cpu_drive(we, f3, addr, 32'h1234_5678);
    @(negedge clk);
    chk("mis_pulse", 32'(bus.cpu_misalign), 32'd1);
    chk("mis_no_en", 32'(bus.mem_en), 32'd0);
    chk("mis_stall", 32'(bus.cpu_stall), 32'd0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("mis_one_pulse", 32'(bus.cpu_misalign), 32'd0);
  endtask

  task automatic dbg_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = addr; bus.dbg_wdata = data;
    @(negedge clk);
    chk("dbg_wr_ready", 32'(bus.dbg_ready), 32'd1);
    chk("dbg_wr_be", 32'(bus.mem_be), 32'hF);
    chk("dbg_wr_data", bus.mem_wdata, data);
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
  endtask

  task automatic dbg_read(input logic [31:0] addr, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = addr;
    @(negedge clk);
    chk("dbg_rd_ready", 32'(bus.dbg_ready), 32'd1);
    chk("dbg_rd_en", 32'(bus.mem_en), 32'd1);
    chk("dbg_rd_be", 32'(bus.mem_be), 32'd0);
    chk("dbg_rd_addr", 32'(bus.mem_addr), 32'(addr[ADDR_W-1:2]));
    dbg_exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("dbg_rd_no_grant", 32'(bus.mem_en), 32'd0);
  endtask

  // CPU issues LW @0x10 back to back while DBG holds a read request
  task automatic starve_round(input logic [31:0] daddr, input logic [31:0] dexp);
    int losses;
    bit got;
    losses = 0;
    got    = 1'b0;
    @(posedge clk); #1;
    cpu_drive(1'b0, F3_W, 32'h10, 32'h0);
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = daddr;
    for (int i = 0; i < 4 * STARVE_MAX + 8 && !got; i++) begin
      @(negedge clk);
      if (bus.dbg_ready) got = 1'b1;
      else begin
        if (bus.mem_en) begin
          losses++;
          cpu_exp_q.push_back(32'h80AD_BEEF);
        end
        @(posedge clk); #1;
      end
    end
    chk("starve_granted", 32'(got), 32'd1);
    chk("starve_losses", 32'(losses), 32'(STARVE_MAX));
    if (got) begin
      chk("starve_cpu_stall", 32'(bus.cpu_stall), 32'd1);
      chk("starve_dbg_addr", 32'(bus.mem_addr), 32'(daddr[ADDR_W-1:2]));
      dbg_exp_q.push_back(dexp);
      @(posedge clk); #1;
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("wait_dbg_cpu_stall", 32'(bus.cpu_stall), 32'd1);
      chk("wait_dbg_no_grant", 32'(bus.mem_en), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("cpu_after_dbg_en", 32'(bus.mem_en), 32'd1);
      cpu_exp_q.push_back(32'h80AD_BEEF);
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
  endtask

  // directed sequence
  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b0;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'h0;
    #3;
    chk("rst_state", 32'(bus.arb_state), 32'(IDLE));
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_dbg_ready", 32'(bus.dbg_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cpu_store(F3_W, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    cpu_load(F3_W, 32'h10, 32'hDEAD_BEEF);
    cpu_store(F3_B, 32'h13, 32'h0000_0080, 4'b1000, 32'h8080_8080);
    cpu_load(F3_B, 32'h13, 32'hFFFF_FF80);
    cpu_load(F3_BU, 32'h13, 32'h0000_0080);
    cpu_load(F3_B, 32'h11, 32'hFFFF_FFBE);
    cpu_store(F3_H, 32'h16, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    cpu_load(F3_H, 32'h16, 32'h0000_1234);
    cpu_load(F3_HU, 32'h12, 32'h0000_80AD);
    cpu_load(F3_H, 32'h12, 32'hFFFF_80AD);
    cpu_load(F3_W, 32'h0000_1010, 32'h80AD_BEEF);

    cpu_reject(1'b0, F3_H, 32'h11);
    cpu_reject(1'b1, F3_W, 32'h12);
    cpu_reject(1'b0, 3'b011, 32'h10);

    dbg_read(32'h10, 32'h80AD_BEEF);
    dbg_write(32'h20, 32'hCAFE_F00D);
    dbg_read(32'h22, 32'hCAFE_F00D);
    cpu_load(F3_W, 32'h20, 32'hCAFE_F00D);

    starve_round(32'h14, 32'h1234_0000);
    starve_round(32'h10, 32'h80AD_BEEF);

    for (int i = 0; i < 4; i++) begin
      ra = {20'h0, 8'($urandom_range(64, 127)), 2'b00, 2'b00};
      rd = $urandom;
      cpu_store(F3_W, ra, rd, 4'hF, rd);
      cpu_load(F3_W, ra, rd);
    end

    // reset while a CPU load waits for its data
    @(posedge clk); #1;
    cpu_drive(1'b0, F3_W, 32'h10, 32'h0);
    @(negedge clk);
    chk("rst_ld_stall", 32'(bus.cpu_stall), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.arb_state), 32'(IDLE));
    chk("arst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("arst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("arst_mem_en", 32'(bus.mem_en), 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_state", 32'(bus.arb_state), 32'(IDLE));
    chk("post_rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    repeat (2) @(negedge clk);
    chk("cpu_q_drained", 32'(cpu_exp_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
